// File: rtl/alu_muldiv_seq_if.sv
// Request/response bundle between the multicycle control FSM and the
// iterative multiply/divide unit.
interface alu_muldiv_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             div_by_zero;

  // Handshake: start is a request sampled only while the unit is idle (busy=0);
  // a, b and op are captured on that same edge. done is a one-cycle completion
  // pulse and the result fields are valid from then until the next done.
  // There is no back-pressure: start while busy is dropped, not queued.
  modport master (
    output start, op, a, b,
    input  busy, done, result_lo, result_hi, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result_lo, result_hi, div_by_zero
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned shift-add multiplier / restoring divider.
// Fixed latency of WIDTH iterations regardless of operands, results registered.
module alu_muldiv_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  alu_muldiv_seq_if.slave    bus,
  output logic [1:0]         state_dbg_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_q, op_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [WIDTH-1:0]   iter_hi;
  logic [WIDTH-1:0]   iter_lo;
  logic               cnt_last;

  // MUL: acc_hi is the running partial product, acc_lo the multiplier being
  // consumed LSB first. DIV: acc_hi is the remainder, acc_lo the dividend
  // shifting out MSB first while quotient bits shift in.
  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
  assign div_trial = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ge    = (div_trial >= {1'b0, b_q});
  // The true difference is always below b, so the low WIDTH bits are exact.
  assign div_diff  = div_trial[WIDTH-1:0] - b_q;
  assign cnt_last  = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    iter_hi = acc_hi_q;
    iter_lo = acc_lo_q;
    if (op_q) begin
      iter_hi = div_ge ? div_diff : div_trial[WIDTH-1:0];
      iter_lo = {acc_lo_q[WIDTH-2:0], div_ge};
    end else begin
      iter_hi = mul_sum[WIDTH:1];
      iter_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    b_d      = b_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    dbz_d    = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          op_d     = bus.op;
          b_d      = bus.b;
          acc_hi_d = '0;
          acc_lo_d = bus.a;
        end
      end
      S_RUN: begin
        acc_hi_d = iter_hi;
        acc_lo_d = iter_lo;
        if (cnt_last) begin
          state_d  = S_DONE;
          res_lo_d = iter_lo;
          res_hi_d = iter_hi;
          dbz_d    = op_q && (b_q == '0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      b_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      b_q      <= b_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.result_lo   = res_lo_q;
  assign bus.result_hi   = res_hi_q;
  assign bus.div_by_zero = dbz_q;
  assign state_dbg_o     = state_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: latency, products, quotients,
// divide-by-zero, start-while-busy and mid-operation reset.
module tb_alu_muldiv_seq;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  int         checks;
  int         errors;
  int         lat;
  int         busy_cnt;
  int         done_cnt;

  alu_muldiv_seq_if #(.WIDTH(16)) bus ();

  alu_muldiv_seq #(.WIDTH(16), .CNT_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .state_dbg_o (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one start pulse and watch 24 cycles after the start edge. If
  // glitch_at >= 0, new operands and a start pulse are driven at that cycle.
  task automatic run_op(input logic op_v, input logic [15:0] a_v, input logic [15:0] b_v,
                        input int glitch_at,
                        output int lat_o, output int busy_o, output int done_o);
    bus.op    = op_v;
    bus.a     = a_v;
    bus.b     = b_v;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat_o  = -1;
    busy_o = 0;
    done_o = 0;
    for (int i = 0; i < 24; i++) begin
      if (bus.busy) busy_o++;
      if (bus.done) begin
        done_o++;
        if (lat_o < 0) lat_o = i;
      end
      if (i == glitch_at) begin
        bus.a     = 16'h0002;
        bus.b     = 16'h0003;
        bus.op    = ~op_v;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_op(input string tag, input logic [15:0] lo, input logic [15:0] hi,
                          input logic dbz);
    chk({tag, "_latency"}, 32'(lat), 32'd16);
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd17);
    chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({tag, "_result_lo"}, 32'(bus.result_lo), 32'(lo));
    chk({tag, "_result_hi"}, 32'(bus.result_hi), 32'(hi));
    chk({tag, "_div_by_zero"}, 32'(bus.div_by_zero), 32'(dbz));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    // Reset, then 5 idle cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_result_lo", 32'(bus.result_lo), 32'h0000);
    chk("reset_result_hi", 32'(bus.result_hi), 32'h0000);
    chk("reset_div_by_zero", 32'(bus.div_by_zero), 32'd0);
    chk("reset_state", 32'(state_dbg), 32'd0);

    // 300*300 = 90000 = 0x0001_5F90
    run_op(1'b0, 16'd300, 16'd300, -1, lat, busy_cnt, done_cnt);
    check_op("mul_300x300", 16'h5F90, 16'h0001, 1'b0);

    // 0xFFFF*0xFFFF = 0xFFFE_0001 (exercises the carry bit)
    run_op(1'b0, 16'hFFFF, 16'hFFFF, -1, lat, busy_cnt, done_cnt);
    check_op("mul_ffff", 16'h0001, 16'hFFFE, 1'b0);

    // 1000/7 = 142 r 6
    run_op(1'b1, 16'd1000, 16'd7, -1, lat, busy_cnt, done_cnt);
    check_op("div_1000_7", 16'h008E, 16'h0006, 1'b0);

    // Divide by zero: quotient all ones, remainder = dividend
    run_op(1'b1, 16'h04D2, 16'h0000, -1, lat, busy_cnt, done_cnt);
    check_op("div_by_0", 16'hFFFF, 16'h04D2, 1'b1);

    // 0x0123*0x0456 = 291*1110 = 323010 = 0x0004_EDC2; new operands and a
    // start pulse at cycle 5 must be ignored.
    run_op(1'b0, 16'h0123, 16'h0456, 5, lat, busy_cnt, done_cnt);
    check_op("mul_start_busy", 16'hEDC2, 16'h0004, 1'b0);
    chk("mul_start_busy_state_idle", 32'(state_dbg), 32'd0);

    // Reset at cycle 8 of a divide: outputs clear before any clock edge.
    bus.op    = 1'b1;
    bus.a     = 16'd1000;
    bus.b     = 16'd7;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    chk("midrst_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_result_lo", 32'(bus.result_lo), 32'h0000);
    chk("midrst_result_hi", 32'(bus.result_hi), 32'h0000);
    chk("midrst_div_by_zero", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      if (bus.done) done_cnt++;
    end
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    chk("midrst_state_idle", 32'(state_dbg), 32'd0);

    // Unit still works after the aborted operation: 100/9 = 11 r 1
    run_op(1'b1, 16'd100, 16'd9, -1, lat, busy_cnt, done_cnt);
    check_op("div_after_rst", 16'h000B, 16'h0001, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Iterative multicycle multiply/divide unit for the multicycle datapath. It sits directly upstream of the ALU output register.
- The control FSM pulses `start` with two operands and an op select. The unit grinds for WIDTH cycles, then presents a registered result with a one-cycle `done` pulse.
- The controller loads the ALU output register on `done`.
- Arithmetic is unsigned shift-add multiply and restoring divide.

Parameters:
- WIDTH, 16, operand/result width; iteration count equals WIDTH.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  1  0 = MUL (unsigned), 1 = DIV (unsigned)
- a  input  WIDTH  multiplicand / dividend; sampled with start
- b  input  WIDTH  multiplier / divisor; sampled with start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse, high in DONE
- result_lo  output  WIDTH  MUL: product[WIDTH-1:0]; DIV: quotient
- result_hi  output  WIDTH  MUL: product[2*WIDTH-1:WIDTH]; DIV: remainder
- div_by_zero  output  1  high with result when op=DIV and b=0

Behaviour:
- Reset is asserted at any time, including mid-operation:
  - state goes to IDLE; counter and working registers clear.
  - busy=0, done=0, result_lo=0, result_hi=0, div_by_zero=0.
  - An in-flight operation is discarded and no done pulse is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at edge k: latch a, b, op; set counter=0; go to RUN.
  - If start=0: stay in IDLE.
- RUN:
  - One iteration per edge, edges k+1..k+16 for WIDTH=16.
  - On the edge where counter==WIDTH-1, load result_lo/result_hi/div_by_zero and go to DONE.
  - Otherwise increment the counter.
- DONE: done=1 for exactly one cycle (between edges k+16 and k+17), then IDLE.
- Latency: done is visible WIDTH cycles after the start-sampling edge. Latency is fixed and independent of operand values and div-by-zero.
- MUL iteration:
  - 2*WIDTH accumulator {hi, lo}; lo initialised to a, hi to 0.
  - Each step: if lo[0], hi += b with carry kept in a WIDTH+1 temporary.
  - Then shift {carry, hi, lo} right by 1.
  - The full 2*WIDTH product is exact; no overflow flag.
- DIV iteration (restoring):
  - rem initialised to 0, quo to a.
  - Each step: shift {rem, quo} left by 1, forming a WIDTH+1-bit trial.
  - If trial rem >= b: rem -= b and quo[0]=1; else quo[0]=0.
- Divide by zero:
  - There is no special path; the algorithm runs its normal WIDTH iterations.
  - This naturally yields quotient = all ones and remainder = a.
  - div_by_zero = (b_latched == 0) && op_latched, registered with the results.
  - For MUL, div_by_zero=0.
- Outputs:
  - result_lo, result_hi and div_by_zero are registered and change only on the RUN->DONE edge.
  - They hold their value through IDLE until the next completion.
  - Partial values never appear on the outputs.
- start while busy (RUN or DONE) is ignored: no re-latch, no queueing. The controller must re-issue it after done.
- a/b/op changes after the sampling edge have no effect on the running operation.
- start held high continuously: a new operation launches on the first IDLE edge after DONE. Back-to-back throughput is WIDTH+2 cycles per operation.

Test Plan:
- Reset, then idle 5 cycles -> busy=0, done=0, result_lo=0x0000, result_hi=0x0000, div_by_zero=0.
- MUL a=300, b=300, start 1 cycle -> done exactly 16 cycles after the start edge; result_hi=0x0001, result_lo=0x5F90; busy high for 17 cycles.
- MUL a=0xFFFF, b=0xFFFF -> result_hi=0xFFFE, result_lo=0x0001 (carry path).
- DIV a=1000, b=7 -> result_lo=0x008E, result_hi=0x0006, div_by_zero=0.
- DIV a=0x04D2, b=0 -> result_lo=0xFFFF, result_hi=0x04D2, div_by_zero=1, same 16-cycle latency.
- Robustness sequence:
  - Start a MUL, change a/b and pulse start at cycle 5 -> the original result is delivered and only one done pulse occurs.
  - Assert rst at cycle 8 of a DIV -> outputs are 0 immediately (asynchronously) and no done pulse follows.
